// File: rtl/prio_encode_pkg.sv
// =============================================================================
// prio_encode_pkg : shared types and reset values for prio_encode_stage
// Revision        : 1.0
// =============================================================================
`default_nettype none

package prio_encode_pkg;

  // Widest code that any legal REQ_W (at most 16) can produce.
  localparam int MAX_CODE_W = 4;
  localparam int MIN_REQ_W  = 2;
  localparam int MAX_REQ_W  = 16;

  // Queue occupancy doubles as the FSM state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    logic [MAX_CODE_W-1:0] code;
    logic                  none;
  } entry_t;

  localparam occ_e   RST_STATE = EMPTY;
  localparam entry_t RST_ENTRY = '{code: '0, none: 1'b0};

endpackage : prio_encode_pkg

`default_nettype wire

// File: rtl/lsb_prio_enc.sv
// =============================================================================
// lsb_prio_enc : combinational lowest-index-wins priority encoder
// Revision     : 1.0
// =============================================================================
`default_nettype none

module lsb_prio_enc #(
  parameter int REQ_W  = 4,
  parameter int CODE_W = $clog2(REQ_W)
) (
  input  logic [REQ_W-1:0]  req_i,
  output logic [CODE_W-1:0] code_o,
  output logic              none_o
);

  // Scan from the top so that the lowest set bit is the last one written.
  always_comb begin
    code_o = '0;
    none_o = 1'b1;
    for (int i = REQ_W - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        code_o = CODE_W'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule : lsb_prio_enc

`default_nettype wire

// File: rtl/prio_encode_stage.sv
// =============================================================================
// prio_encode_stage : registered priority encoder with 2-entry output queue
// Revision          : 1.0
// =============================================================================
`default_nettype none

module prio_encode_stage
  import prio_encode_pkg::*;
#(
  parameter int REQ_W  = 4,
  parameter int CODE_W = $clog2(REQ_W),
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REQ_W-1:0]  in_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_none,
  output logic [CNT_W-1:0]  enc_cnt,
  output logic [CNT_W-1:0]  none_cnt
);

  generate
    if ((REQ_W < MIN_REQ_W) || (REQ_W > MAX_REQ_W)) begin : g_bad_req_w
      $error("prio_encode_stage: REQ_W out of range");
    end
  endgenerate

  occ_e             state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
  logic [CNT_W-1:0] none_cnt_q, none_cnt_d;

  logic [CODE_W-1:0] enc_code;
  logic              enc_none;
  entry_t            new_entry;
  logic              push;
  logic              pop;

  lsb_prio_enc #(
    .REQ_W  (REQ_W),
    .CODE_W (CODE_W)
  ) u_enc (
    .req_i  (in_req),
    .code_o (enc_code),
    .none_o (enc_none)
  );

  assign new_entry.code = MAX_CODE_W'(enc_code);
  assign new_entry.none = enc_none;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_code  = head_q.code[CODE_W-1:0];
  assign out_none  = head_q.none;
  assign enc_cnt   = enc_cnt_q;
  assign none_cnt  = none_cnt_q;

  generate
    if (CODE_W < MAX_CODE_W) begin : g_code_pad
      logic unused_code_pad;
      assign unused_code_pad = &{1'b0, head_q.code[MAX_CODE_W-1:CODE_W]};
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    enc_cnt_d  = enc_cnt_q;
    none_cnt_d = none_cnt_q;

    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Counters saturate at all-ones rather than wrapping.
    if (push) begin
      if (!enc_none) begin
        if (enc_cnt_q != {CNT_W{1'b1}}) begin
          enc_cnt_d = enc_cnt_q + 1'b1;
        end
      end else begin
        if (none_cnt_q != {CNT_W{1'b1}}) begin
          none_cnt_d = none_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      head_q     <= RST_ENTRY;
      tail_q     <= RST_ENTRY;
      enc_cnt_q  <= '0;
      none_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      enc_cnt_q  <= enc_cnt_d;
      none_cnt_q <= none_cnt_d;
    end
  end

endmodule : prio_encode_stage

`default_nettype wire

// File: tb/tb_prio_encode_stage.sv
// =============================================================================
// tb_prio_encode_stage : directed + random bench with a queue-based model
// Revision             : 1.0
// =============================================================================
`default_nettype none

module tb_prio_encode_stage;

  localparam int REQ_W  = 4;
  localparam int CODE_W = 2;
  localparam int CNT_W  = 8;
  localparam int SAT_W  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [REQ_W-1:0] in_req = '0;

  logic              in_ready, out_valid, out_none;
  logic [CODE_W-1:0] out_code;
  logic [CNT_W-1:0]  enc_cnt, none_cnt;

  logic              s_in_ready, s_out_valid, s_out_none;
  logic [CODE_W-1:0] s_out_code;
  logic [SAT_W-1:0]  s_enc_cnt, s_none_cnt;

  prio_encode_stage #(.REQ_W(REQ_W), .CNT_W(CNT_W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_req    (in_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_none  (out_none),
    .enc_cnt   (enc_cnt),
    .none_cnt  (none_cnt)
  );

  // Same stimulus, narrow counters, to exercise saturation.
  prio_encode_stage #(.REQ_W(REQ_W), .CNT_W(SAT_W)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_req    (in_req),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_code  (s_out_code),
    .out_none  (s_out_none),
    .enc_cnt   (s_enc_cnt),
    .none_cnt  (s_none_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    bit none;
  } ent_t;

  ent_t mq[$];
  int   m_enc  = 0;
  int   m_none = 0;
  int   total  = 0;
  int   bad    = 0;

  function automatic ent_t ref_enc(input logic [REQ_W-1:0] r);
    ent_t e;
    int   v;
    int   iso;
    v = int'(r);
    if (v == 0) begin
      e.code = 0;
      e.none = 1'b1;
    end else begin
      iso    = v & (-v);
      e.code = $clog2(iso);
      e.none = 1'b0;
    end
    return e;
  endfunction

  function automatic int sat(input int c, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (c > lim) ? lim : c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    chk({ph, "_in_ready"},  32'(in_ready),  32'(mq.size() < 2));
    if (mq.size() > 0) begin
      chk({ph, "_out_code"}, 32'(out_code), 32'(mq[0].code));
      chk({ph, "_out_none"}, 32'(out_none), 32'(mq[0].none));
      chk({ph, "_sat_code"}, 32'(s_out_code), 32'(mq[0].code));
    end
    chk({ph, "_enc_cnt"},   32'(enc_cnt),    32'(sat(m_enc, CNT_W)));
    chk({ph, "_none_cnt"},  32'(none_cnt),   32'(sat(m_none, CNT_W)));
    chk({ph, "_sat_enc"},   32'(s_enc_cnt),  32'(sat(m_enc, SAT_W)));
    chk({ph, "_sat_none"},  32'(s_none_cnt), 32'(sat(m_none, SAT_W)));
    chk({ph, "_sat_valid"}, 32'(s_out_valid), 32'(mq.size() > 0));
  endtask

  // One clock of stimulus: check outputs at the falling edge, drive inputs,
  // then apply the model's push/pop at the rising edge.
  task automatic step(input string ph, input logic v, input logic [REQ_W-1:0] r,
                      input logic rdy);
    bit   do_push;
    bit   do_pop;
    ent_t e;
    @(negedge clk);
    check_all(ph);
    in_valid  = v;
    in_req    = r;
    out_ready = rdy;
    do_push = v && (mq.size() < 2);
    do_pop  = rdy && (mq.size() > 0);
    e = ref_enc(r);
    @(posedge clk);
    if (rst_n) begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(e);
        if (e.none) m_none++;
        else m_enc++;
      end
    end
  endtask

  initial begin
    logic [REQ_W-1:0] prio_vec [5];
    int               prio_exp [5];
    prio_vec = '{4'b1010, 4'b1100, 4'b1000, 4'b0001, 4'b1111};
    prio_exp = '{1, 2, 3, 0, 0};

    // Reset held low for three cycles under random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("rst", 1'($urandom), REQ_W'($urandom), 1'($urandom));
    end
    #1;
    chk("rst_out_code", 32'(out_code), 32'd0);
    chk("rst_out_none", 32'(out_none), 32'd0);
    @(negedge clk);
    check_all("rst_rel");
    in_valid = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step("prio", 1'b1, prio_vec[i], 1'b1);
      #1;
      chk("prio_code", 32'(out_code), 32'(prio_exp[i]));
      chk("prio_valid", 32'(out_valid), 32'd1);
    end
    chk("prio_enc5", 32'(enc_cnt), 32'd5);
    chk("prio_sat3", 32'(s_enc_cnt), 32'd3);

    step("zero", 1'b1, 4'b0000, 1'b1);
    #1;
    chk("zero_none", 32'(out_none), 32'd1);
    chk("zero_code", 32'(out_code), 32'd0);
    chk("zero_ncnt", 32'(none_cnt), 32'd1);
    chk("zero_ecnt", 32'(enc_cnt),  32'd5);
    step("drain", 1'b0, 4'b0000, 1'b1);

    step("bp", 1'b1, 4'b0100, 1'b0);
    step("bp", 1'b1, 4'b0010, 1'b0);
    #1;
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_full_code",  32'(out_code), 32'd2);
    step("bp", 1'b1, 4'b0001, 1'b0);
    step("bp", 1'b0, 4'b0000, 1'b0);
    #1;
    chk("bp_hold_code", 32'(out_code), 32'd2);
    step("bp", 1'b0, 4'b0000, 1'b1);
    #1;
    chk("bp_second_code", 32'(out_code), 32'd1);
    chk("bp_ready_back",  32'(in_ready), 32'd1);
    step("bp", 1'b0, 4'b0000, 1'b1);
    #1;
    chk("bp_empty", 32'(out_valid), 32'd0);

    for (int i = 0; i < 6; i++) begin
      step("pp", 1'b1, 4'b1000, 1'b1);
      #1;
      chk("pp_valid", 32'(out_valid), 32'd1);
      chk("pp_code",  32'(out_code),  32'd3);
      chk("pp_ready", 32'(in_ready),  32'd1);
    end

    for (int i = 0; i < 250; i++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), REQ_W'($urandom),
           1'($urandom_range(0, 2) != 0));
    end

    // Fill both entries, then assert reset between edges.
    for (int i = 0; i < 3; i++) step("fill", 1'b0, 4'b0000, 1'b1);
    step("fill", 1'b1, 4'b0100, 1'b0);
    step("fill", 1'b1, 4'b0010, 1'b0);
    #1;
    chk("fill_full", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  32'(out_valid), 32'd0);
    chk("arst_ready",  32'(in_ready),  32'd1);
    chk("arst_enc",    32'(enc_cnt),   32'd0);
    chk("arst_none",   32'(none_cnt),  32'd0);
    chk("arst_satenc", 32'(s_enc_cnt), 32'd0);
    chk("arst_code",   32'(out_code),  32'd0);
    mq.delete();
    m_enc  = 0;
    m_none = 0;
    step("arst", 1'b1, 4'b0110, 1'b0);
    @(negedge clk);
    check_all("arst_rel");
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step("post", 1'b1, 4'b0110, 1'b1);
    step("post", 1'b1, 4'b0000, 1'b0);
    step("post", 1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_prio_encode_stage

`default_nettype wire

// File: doc/prio_encode_stage.md
# prio_encode_stage

Registered, handshaked priority-encode stage that sits directly upstream of the case-decoding logic. It accepts a one-hot-ish request vector, resolves it to a binary code with fixed lowest-index-wins priority (bit 0 highest), and buffers results in a 2-entry output queue with a valid/ready handshake. It also keeps saturating statistics counters. The downstream decoder therefore always receives a resolved, unambiguous code and never a raw multi-hot vector.

## Interface
Parameters:
- REQ_W, 4, request vector width; legal range 2..16.
- CODE_W, $clog2(REQ_W), encoded output width (derived, not overridden).
- CNT_W, 8, width of each statistics counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk externally.
- in_valid  in  1  upstream request vector valid.
- in_ready  out  1  stage can accept; high when the queue holds fewer than 2 entries.
- in_req  in  REQ_W  request vector.
- out_valid  out  1  head of queue valid.
- out_ready  in  1  downstream accepts the head.
- out_code  out  CODE_W  index of lowest set bit of the accepted vector.
- out_none  out  1  accepted vector was all zeros.
- enc_cnt  out  CNT_W  number of vectors accepted with at least one bit set; saturating.
- none_cnt  out  CNT_W  number of all-zero vectors accepted; saturating.

## Operation
- A push occurs when in_valid && in_ready. A pop occurs when out_valid && out_ready.
- Encoding:
  - out_code is the index of the lowest set bit of in_req.
  - For in_req == 0: out_code = 0 and out_none = 1.
  - The encoder is fully specified for every input value: no don't-care outputs and no latch inference.
- Queue: 2 entries of {code, none}. Entries leave in FIFO order.
- FSM, state = queue occupancy:
  - EMPTY: push only → ONE. Idle → EMPTY.
  - ONE: push only → TWO. Pop only → EMPTY. Push and pop in the same cycle → ONE; the head is replaced by the new entry.
  - TWO: pop → ONE. in_ready = 0, so a push cannot occur.
  - Unused state encodings return to EMPTY on the next clock.
- Flags: out_valid = (state != EMPTY). in_ready = (state != TWO).
- Counters:
  - On each push, increment enc_cnt if in_req != 0, otherwise increment none_cnt.
  - Each counter holds at 2^CNT_W-1 and never wraps.
- Reset:
  - The FSM goes to EMPTY.
  - out_valid=0, out_code=0, out_none=0, enc_cnt=0, none_cnt=0, in_ready=1.
  - Reset asserted mid-transfer discards all queued entries immediately. The discarded entries are not counted again.
- out_code and out_none hold stable while out_valid=1 and out_ready=0.

## Timing
- Latency: a vector pushed at edge N is visible on out_code/out_none with out_valid=1 after edge N. There are no combinational paths from in_* to out_*.
- Combinational paths:
  - in_ready depends only on registered state, not on out_ready. There is no ready pass-through.
  - out_valid, out_code and out_none are driven from registers.
- Throughput: 1 vector per cycle while out_ready is held high.
- Counters update at the same edge as the push that causes the increment.

## Structure
- Package prio_encode_pkg holds:
  - the occupancy state enum (EMPTY, ONE, TWO);
  - the queue entry struct {code, none};
  - the reset constants.
- Sub-module lsb_prio_enc holds the combinational, parameterised REQ_W → {CODE_W code, none} encoder. It is instantiated once at the input; results are stored already encoded.
- The top level contains the FSM, the 2-entry storage and the counters, all in one clocked process plus one next-state process.

## Test plan
- Reset then idle: rst_n low for 3 cycles with random inputs → out_valid=0, in_ready=1, enc_cnt=none_cnt=0.
- Priority: push 4'b1010, 4'b1100, 4'b1000, 4'b0001, 4'b1111 with out_ready=1 → out_code = 1, 2, 3, 0, 0 respectively, each one cycle after its push; enc_cnt=5.
- Zero vector: push 4'b0000 → out_none=1, out_code=0, none_cnt=1, enc_cnt unchanged.
- Backpressure:
  - Hold out_ready=0 and push 4'b0100, then 4'b0010 → in_ready=0 after the second push, out_code=2 held stable, the third vector is not accepted.
  - Release out_ready → codes 2 then 1 appear in order, then in_ready=1.
- Simultaneous push/pop in ONE, out_ready=1, continuous in_valid with 4'b1000 → out_valid stays 1, out_code=3 every cycle, state never reaches TWO.
- Saturation and reset: CNT_W=2, push 5 nonzero vectors → enc_cnt=3.
  - Then assert rst_n while the queue holds 2 entries → out_valid=0 and enc_cnt=0 immediately, without waiting for a clock edge.
